// File: rtl/eip_pkg.sv
`default_nettype none
// ============================================================================
//  Module : eip_pkg
//  Brief  : Shared register indices and FSM encoding for the external
//           interrupt controller.
//  Rev    : 1.0
// ============================================================================
package eip_pkg;

   localparam logic [2:0] EIP_PENDING = 3'd0;
   localparam logic [2:0] EIP_ENABLE  = 3'd1;
   localparam logic [2:0] EIP_CLAIM   = 3'd2;
   localparam logic [2:0] EIP_EDGE    = 3'd3;
   localparam logic [2:0] EIP_STATUS  = 3'd4;

   localparam int unsigned EIP_ID_W = 5;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'b00,
      ST_ASSERT  = 2'b01,
      ST_WAITCLM = 2'b10,
      ST_SERVICE = 2'b11
   } eip_state_e;

endpackage
`default_nettype wire

// File: rtl/eip_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module : eip_ctrl_if
//  Brief  : Register window, interrupt lines and privilege-unit handshake.
//  Rev    : 1.0
// ============================================================================
interface eip_ctrl_if #(
   parameter int NSRC = 8
);
   logic [2:0]      a;
   logic [31:0]     d;
   logic            we;
   logic            rd;
   logic [31:0]     spo;
   logic [NSRC-1:0] irq_in;
   logic            m_eip;
   logic            m_eip_reply;

   modport master (
      output a, d, we, rd, irq_in, m_eip_reply,
      input  spo, m_eip
   );

   modport slave (
      input  a, d, we, rd, irq_in, m_eip_reply,
      output spo, m_eip
   );
endinterface
`default_nettype wire

// File: rtl/eip_sync.sv
`default_nettype none
// ============================================================================
//  Module : eip_sync
//  Brief  : Multi-bit flop-chain synchronizer with asynchronous reset.
//  Rev    : 1.0
// ============================================================================
module eip_sync #(
   parameter int WIDTH  = 1,
   parameter int STAGES = 2
) (
   input  wire logic             clk,
   input  wire logic             rst,
   input  wire logic [WIDTH-1:0] i_async,
   output logic      [WIDTH-1:0] o_sync
);

   logic [WIDTH-1:0] chain_q [STAGES];
   logic [WIDTH-1:0] chain_d [STAGES];

   always_comb begin
      chain_d[0] = i_async;
      for (int i = 1; i < STAGES; i++) begin
         chain_d[i] = chain_q[i-1];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < STAGES; i++) begin
            chain_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < STAGES; i++) begin
            chain_q[i] <= chain_d[i];
         end
      end
   end

   assign o_sync = chain_q[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/eip_ctrl.sv
`default_nettype none
// ============================================================================
//  Module : eip_ctrl
//  Brief  : External-interrupt controller: pending latch, claim/complete
//           register window and m_eip request handshake.
//  Rev    : 1.0
// ============================================================================
module eip_ctrl #(
   parameter int NSRC        = 8,
   parameter int SYNC_STAGES = 2
) (
   input wire logic  clk,
   input wire logic  rst,
   eip_ctrl_if.slave bus
);
   import eip_pkg::*;

   logic [NSRC-1:0]     w_s;
   logic [NSRC-1:0]     s_dly_q,  s_dly_d;
   logic [NSRC-1:0]     pend_q,   pend_d;
   logic [NSRC-1:0]     en_q,     en_d;
   logic [NSRC-1:0]     trig_q,   trig_d;
   logic [EIP_ID_W-1:0] insvc_q,  insvc_d;
   eip_state_e          state_q,  state_d;
   logic                m_eip_q,  m_eip_d;

   logic [EIP_ID_W-1:0] w_claim_id;
   logic                w_claim_rd;
   logic                w_claim_ok;
   logic                w_claim_zero;
   logic                w_cmpl;
   logic [NSRC-1:0]     w_insvc_oh;
   logic [NSRC-1:0]     w_claim_oh;
   logic [NSRC-1:0]     w_set;
   logic [31:0]         w_spo;
   logic                w_unused_d;

   function automatic logic [EIP_ID_W-1:0] lowest_id(input logic [NSRC-1:0] v);
      logic [EIP_ID_W-1:0] id;
      id = '0;
      for (int i = NSRC - 1; i >= 0; i--) begin
         if (v[i]) id = EIP_ID_W'(i + 1);
      end
      return id;
   endfunction

   eip_sync #(
      .WIDTH  (NSRC),
      .STAGES (SYNC_STAGES)
   ) u_sync (
      .clk     (clk),
      .rst     (rst),
      .i_async (bus.irq_in),
      .o_sync  (w_s)
   );

   assign w_claim_id   = lowest_id(pend_q & en_q);
   assign w_claim_rd   = bus.rd && (bus.a == EIP_CLAIM);
   assign w_claim_ok   = w_claim_rd && (w_claim_id != '0);
   assign w_claim_zero = w_claim_rd && (w_claim_id == '0);
   // A CLAIM read in the same cycle as a CLAIM write swallows the write.
   assign w_cmpl       = bus.we && !bus.rd && (bus.a == EIP_CLAIM) &&
                         (insvc_q != '0) && (bus.d[EIP_ID_W-1:0] == insvc_q);
   assign w_unused_d   = ^bus.d;

   for (genvar gi = 0; gi < NSRC; gi++) begin : g_src
      assign w_insvc_oh[gi] = (insvc_q == EIP_ID_W'(gi + 1));
      assign w_claim_oh[gi] = w_claim_ok && (w_claim_id == EIP_ID_W'(gi + 1));
   end

   // A level line being claimed this cycle is treated as already in service,
   // otherwise it would re-pend on the very edge that claims it.
   assign w_set = (trig_q & w_s & ~s_dly_q) |
                  (~trig_q & w_s & ~w_insvc_oh & ~w_claim_oh);

   assign s_dly_d = w_s;
   assign pend_d  = (pend_q & ~w_claim_oh) | w_set;

   always_comb begin
      en_d    = en_q;
      trig_d  = trig_q;
      insvc_d = insvc_q;
      if (bus.we && (bus.a == EIP_ENABLE)) en_d   = bus.d[NSRC-1:0];
      if (bus.we && (bus.a == EIP_EDGE))   trig_d = bus.d[NSRC-1:0];
      if (w_claim_ok) begin
         insvc_d = w_claim_id;
      end else if (w_cmpl) begin
         insvc_d = '0;
      end
   end

   always_comb begin
      state_d = state_q;
      m_eip_d = m_eip_q;
      case (state_q)
         ST_IDLE: begin
            if (|(pend_q & en_q) && (insvc_q == '0)) begin
               state_d = ST_ASSERT;
               m_eip_d = 1'b1;
            end
         end
         ST_ASSERT: begin
            if (w_claim_ok) begin
               state_d = ST_SERVICE;
               m_eip_d = 1'b0;
            end else if (bus.m_eip_reply) begin
               state_d = ST_WAITCLM;
               m_eip_d = 1'b0;
            end
         end
         ST_WAITCLM: begin
            if (w_claim_ok) begin
               state_d = ST_SERVICE;
            end else if (w_claim_zero) begin
               state_d = ST_IDLE;
            end
         end
         ST_SERVICE: begin
            if (w_cmpl) state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
            m_eip_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s_dly_q <= '0;
         pend_q  <= '0;
         en_q    <= '0;
         trig_q  <= '0;
         insvc_q <= '0;
         state_q <= ST_IDLE;
         m_eip_q <= 1'b0;
      end else begin
         s_dly_q <= s_dly_d;
         pend_q  <= pend_d;
         en_q    <= en_d;
         trig_q  <= trig_d;
         insvc_q <= insvc_d;
         state_q <= state_d;
         m_eip_q <= m_eip_d;
      end
   end

   always_comb begin
      w_spo = '0;
      case (bus.a)
         EIP_PENDING: w_spo[NSRC-1:0]     = pend_q;
         EIP_ENABLE:  w_spo[NSRC-1:0]     = en_q;
         EIP_CLAIM:   w_spo[EIP_ID_W-1:0] = w_claim_id;
         EIP_EDGE:    w_spo[NSRC-1:0]     = trig_q;
         EIP_STATUS:  w_spo[6:0]          = {state_q, insvc_q};
         default:     w_spo               = '0;
      endcase
   end

   assign bus.spo   = w_spo;
   assign bus.m_eip = m_eip_q;

endmodule
`default_nettype wire
